mem_stream_rr_arbiter: RTL and testbench
========================================

Name: mem_stream_rr_arbiter

Overview:
- Shares one memory stream port (req/gnt/addr/wdata/strb/we, rvalid/rdata) between NumReq requesters, e.g. several axi_to_mem bank outputs contending for one SRAM bank.
- Arbitration is round-robin, and each grant's requester index is recorded in an in-order route FIFO.
- Each memory response (one per request, read or write) is steered back to the requester that issued it.

Parameters:
- NumReq, 2, number of requesters (>=2).
- AddrWidth, 32, byte address width.
- DataWidth, 32, data width (multiple of 8).
- MaxOutstanding, 2, route FIFO depth: max granted-but-unanswered requests (>=1); set to memory latency.
- IdxWidth, max(1,$clog2(NumReq)), dependent, do not override.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous reset, active low.
- busy_o  out  1  at least one request outstanding.
- req_i  in  NumReq  requester request valid.
- gnt_o  out  NumReq  one-hot grant; request accepted when req_i[i]&gnt_o[i].
- addr_i  in  NumReq x AddrWidth  per-requester address.
- wdata_i  in  NumReq x DataWidth  per-requester write data.
- strb_i  in  NumReq x DataWidth/8  per-requester byte strobe.
- we_i  in  NumReq  per-requester write enable.
- rvalid_o  out  NumReq  one-hot response valid.
- rdata_o  out  DataWidth  response data, broadcast to all requesters.
- mem_req_o  out  1  memory request valid.
- mem_gnt_i  in  1  memory grant.
- mem_addr_o  out  AddrWidth  winner address.
- mem_wdata_o  out  DataWidth  winner write data.
- mem_strb_o  out  DataWidth/8  winner strobe.
- mem_we_o  out  1  winner write enable.
- mem_rvalid_i  in  1  memory response valid, in request order.
- mem_rdata_i  in  DataWidth  memory response data.

Behaviour:
- Reset (async, rst_ni low):
  - rr_q=0, route FIFO empty, count_q=0.
  - All outputs 0: gnt_o, rvalid_o, mem_req_o, busy_o; mem_* payload 0.
  - Reset mid-transaction discards all outstanding routes; responses arriving afterwards are dropped.
- Winner selection (combinational): first index i scanning rr_q, rr_q+1, ... wrapping NumReq-1->0, with req_i[i]=1.
- full = (count_q==MaxOutstanding).
- mem_req_o = |req_i & ~full.
- mem_addr_o/wdata_o/strb_o/we_o = winner's inputs when mem_req_o, else 0.
- gnt_o[winner] = mem_gnt_i & mem_req_o; all other gnt_o bits 0.
- Zero-latency request path; no request register.
- Handshake (mem_req_o & mem_gnt_i):
  - push winner index into route FIFO.
  - rr_q <= winner==NumReq-1 ? 0 : winner+1.
  - rr_q holds when there is no handshake.
- Requesters keep req_i and payload stable until granted. The arbiter may change the winner while the memory stalls (mem_gnt_i=0); this is legal because no grant was issued.
- Response path:
  - on mem_rvalid_i with FIFO non-empty: rvalid_o[head]=1 same cycle, rdata_o=mem_rdata_i, pop head.
  - rdata_o=mem_rdata_i always (no gating).
- Response latency through block: 0 cycles.
- count_q: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full is evaluated on registered count_q only: a pop in the same cycle does not unblock a push; the push is accepted next cycle.
- mem_rvalid_i with FIFO empty: no rvalid_o, count_q stays 0 (never underflows).
- busy_o = (count_q!=0) | mem_req_o.
- FIFO pointers wrap modulo MaxOutstanding; any MaxOutstanding>=1 is supported, not only powers of two.

Optional Feature:
- Macro: MEM_STREAM_RR_ARBITER_ERR_EN.
- With the macro:
  - extra port err_o (out, 1), reset 0.
  - err_o is set sticky on mem_rvalid_i while the FIFO is empty, or on mem_gnt_i without mem_req_o.
  - cleared only by reset.
- Without the macro: port absent; these events are silently ignored as described above.

Test Plan:
- Basic routing: NumReq=2, MaxOutstanding=2, req_i=2'b01, addr_i[0]=0x40, mem_gnt_i=1, rvalid one cycle later:
  - mem_addr_o=0x40, gnt_o=2'b01.
  - next cycle rvalid_o=2'b01, rdata_o=mem_rdata_i.
  - rr_q=1.
- Fairness: NumReq=3, all req_i=1, mem_gnt_i=1 every cycle, responses returned each cycle:
  - gnt_o sequence 001,010,100,001.
  - each rvalid_o lands on the matching requester one cycle after its grant.
- Backpressure: MaxOutstanding=2, no responses:
  - after 2 grants mem_req_o=0 and gnt_o=0.
  - a response in cycle N pops the FIFO; the next grant occurs in cycle N+1, not N.
- Stall reselection: mem_gnt_i=0, req_i=010 then req_i=011 with rr_q=0:
  - winner switches to index 0, with no grant in either cycle.
  - when mem_gnt_i=1, gnt_o=001.
- Reset mid-flight: 2 requests outstanding, pulse rst_ni low asynchronously:
  - all outputs 0 immediately.
  - a later mem_rvalid_i produces no rvalid_o, and err_o=1 if MEM_STREAM_RR_ARBITER_ERR_EN is defined.
- Non-power-of-two wrap: NumReq=3, MaxOutstanding=3:
  - 7 grants and responses to requesters 2,0,1,2,0,1,2 (interleaved) all route correctly across the FIFO pointer wrap.

Source files
------------

// File: rtl/mem_stream_rr_arbiter.sv
// Round-robin arbiter sharing one memory stream port between NumReq requesters.
// Optional sticky protocol-error flag err_o is enabled by MEM_STREAM_RR_ARBITER_ERR_EN.
module mem_stream_rr_arbiter #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  output logic                                   busy_o,
  input  logic [NumReq-1:0]                      req_i,
  output logic [NumReq-1:0]                      gnt_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]       addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]       wdata_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]     strb_i,
  input  logic [NumReq-1:0]                      we_i,
  output logic [NumReq-1:0]                      rvalid_o,
  output logic [DataWidth-1:0]                   rdata_o,
  output logic                                   mem_req_o,
  input  logic                                   mem_gnt_i,
  output logic [AddrWidth-1:0]                   mem_addr_o,
  output logic [DataWidth-1:0]                   mem_wdata_o,
  output logic [DataWidth/8-1:0]                 mem_strb_o,
  output logic                                   mem_we_o,
  input  logic                                   mem_rvalid_i,
  input  logic [DataWidth-1:0]                   mem_rdata_i
`ifdef MEM_STREAM_RR_ARBITER_ERR_EN
  ,
  output logic                                   err_o
`endif
);

  localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  logic [IdxWidth-1:0] rr_q;
  logic [IdxWidth-1:0] winner;
  logic [IdxWidth-1:0] head;
  logic                found;
  logic                full;
  logic                hs;
  logic                pop;
  logic [IdxWidth-1:0] route_q [MaxOutstanding];
  logic [PtrWidth-1:0] wr_ptr_q;
  logic [PtrWidth-1:0] rd_ptr_q;
  logic [CntWidth-1:0] count_q;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  // Two passes: indices at/above rr_q first, then wrap to the lowest requester.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (!found && req_i[i] && (IdxWidth'(i) >= rr_q)) begin
        winner = IdxWidth'(i);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NumReq; i++) begin
      if (!found && req_i[i]) begin
        winner = IdxWidth'(i);
        found  = 1'b1;
      end
    end
  end

  // Full uses the registered count only, so a same-cycle pop never frees a slot early.
  assign full      = (count_q == CntWidth'(MaxOutstanding));
  assign mem_req_o = rst_ni & (|req_i) & ~full;
  assign hs        = mem_req_o & mem_gnt_i;
  assign pop       = mem_rvalid_i & (count_q != '0);
  assign head      = route_q[rd_ptr_q];
  assign busy_o    = (count_q != '0) | mem_req_o;
  assign rdata_o   = mem_rdata_i;

  always_comb begin
    gnt_o       = '0;
    rvalid_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_strb_o  = '0;
    mem_we_o    = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (mem_req_o && (winner == IdxWidth'(i))) begin
        mem_addr_o  = addr_i[i];
        mem_wdata_o = wdata_i[i];
        mem_strb_o  = strb_i[i];
        mem_we_o    = we_i[i];
        gnt_o[i]    = mem_gnt_i;
      end
      if (pop && (head == IdxWidth'(i))) begin
        rvalid_o[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (hs) begin
        rr_q     <= (winner == IdxWidth'(NumReq - 1)) ? '0 : winner + IdxWidth'(1);
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({hs, pop})
        2'b10:   count_q <= count_q + CntWidth'(1);
        2'b01:   count_q <= count_q - CntWidth'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Route storage needs no reset: entries are only read while count_q says they are valid.
  always_ff @(posedge clk_i) begin
    if (hs) begin
      route_q[wr_ptr_q] <= winner;
    end
  end

`ifdef MEM_STREAM_RR_ARBITER_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if ((mem_rvalid_i && (count_q == '0)) || (mem_gnt_i && !mem_req_o)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_mem_stream_rr_arbiter.sv
// Directed bench: instance a (2 requesters, depth 2) and instance b (3 requesters, depth 3).
module tb_mem_stream_rr_arbiter;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic             a_busy, a_mem_req, a_mem_gnt, a_mem_we, a_mem_rvalid;
  logic [1:0]       a_req, a_gnt, a_we, a_rvalid;
  logic [1:0][31:0] a_addr, a_wdata;
  logic [1:0][3:0]  a_strb;
  logic [31:0]      a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]       a_mem_strb;
  logic             a_err;

  logic             b_busy, b_mem_req, b_mem_gnt, b_mem_we, b_mem_rvalid;
  logic [2:0]       b_req, b_gnt, b_we, b_rvalid;
  logic [2:0][31:0] b_addr, b_wdata;
  logic [2:0][3:0]  b_strb;
  logic [31:0]      b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]       b_mem_strb;
  logic             b_err;

  // Wrap schedule: req, mem_gnt, mem_rvalid, expected gnt, expected rvalid.
  localparam logic [2:0] W_REQ [12] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b001,
                                        3'b010, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000};
  localparam logic       W_GNT [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
  localparam logic       W_RV  [12] = '{0, 0, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1};
  localparam logic [2:0] W_EG  [12] = '{3'b100, 3'b001, 3'b010, 3'b000, 3'b100, 3'b001,
                                        3'b010, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000};
  localparam logic [2:0] W_ER  [12] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b001, 3'b010,
                                        3'b000, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000};
  localparam logic [2:0] F_EG  [5]  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000};
  localparam logic [2:0] F_ER  [5]  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001};

  mem_stream_rr_arbiter #(.NumReq(2), .AddrWidth(32), .DataWidth(32), .MaxOutstanding(2)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .busy_o(a_busy),
    .req_i(a_req), .gnt_o(a_gnt), .addr_i(a_addr), .wdata_i(a_wdata), .strb_i(a_strb), .we_i(a_we),
    .rvalid_o(a_rvalid), .rdata_o(a_rdata),
    .mem_req_o(a_mem_req), .mem_gnt_i(a_mem_gnt), .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata),
    .mem_strb_o(a_mem_strb), .mem_we_o(a_mem_we), .mem_rvalid_i(a_mem_rvalid), .mem_rdata_i(a_mem_rdata)
`ifdef MEM_STREAM_RR_ARBITER_ERR_EN
    , .err_o(a_err)
`endif
  );

  mem_stream_rr_arbiter #(.NumReq(3), .AddrWidth(32), .DataWidth(32), .MaxOutstanding(3)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .busy_o(b_busy),
    .req_i(b_req), .gnt_o(b_gnt), .addr_i(b_addr), .wdata_i(b_wdata), .strb_i(b_strb), .we_i(b_we),
    .rvalid_o(b_rvalid), .rdata_o(b_rdata),
    .mem_req_o(b_mem_req), .mem_gnt_i(b_mem_gnt), .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
    .mem_strb_o(b_mem_strb), .mem_we_o(b_mem_we), .mem_rvalid_i(b_mem_rvalid), .mem_rdata_i(b_mem_rdata)
`ifdef MEM_STREAM_RR_ARBITER_ERR_EN
    , .err_o(b_err)
`endif
  );

`ifndef MEM_STREAM_RR_ARBITER_ERR_EN
  assign a_err = 1'b0;
  assign b_err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_req = 2'b11; a_we = 2'b00; a_mem_gnt = 1'b1; a_mem_rvalid = 1'b0; a_mem_rdata = '0;
    a_addr[0] = 32'h40; a_addr[1] = 32'h80;
    a_wdata[0] = 32'hAAAA_0000; a_wdata[1] = 32'h1234_5678;
    a_strb[0] = 4'hF; a_strb[1] = 4'hC;
    b_req = '0; b_we = '0; b_mem_gnt = 1'b0; b_mem_rvalid = 1'b0; b_mem_rdata = '0;
    b_addr[0] = 32'h1000; b_addr[1] = 32'h1010; b_addr[2] = 32'h1020;
    b_wdata = '0; b_strb = '0;

    // Reset holds every control output low even with requests pending
    #2;
    chk("rst_mem_req", a_mem_req, 0);
    chk("rst_gnt", a_gnt, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_rvalid", a_rvalid, 0);
    chk("rst_mem_addr", a_mem_addr, 0);
    chk("rst_mem_wdata", a_mem_wdata, 0);
    chk("rst_err", a_err, 0);
    next_cycle();
    rst_n = 1'b1; a_req = 2'b00; a_mem_gnt = 1'b0;
    next_cycle();

    // Basic routing
    a_req = 2'b01; a_mem_gnt = 1'b1;
    #1;
    chk("basic_mem_addr", a_mem_addr, 32'h40);
    chk("basic_gnt", a_gnt, 2'b01);
    chk("basic_busy", a_busy, 1);
    next_cycle();
    a_req = 2'b00; a_mem_gnt = 1'b0; a_mem_rvalid = 1'b1; a_mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("basic_rvalid", a_rvalid, 2'b01);
    chk("basic_rdata", a_rdata, 32'hDEAD_BEEF);
    next_cycle();

    // rr_q now 1: requester 1 wins over 0 (write path)
    a_mem_rvalid = 1'b0; a_req = 2'b11; a_we = 2'b10; a_mem_gnt = 1'b1;
    #1;
    chk("rr1_gnt", a_gnt, 2'b10);
    chk("rr1_addr", a_mem_addr, 32'h80);
    chk("rr1_we", a_mem_we, 1);
    chk("rr1_wdata", a_mem_wdata, 32'h1234_5678);
    chk("rr1_strb", a_mem_strb, 4'hC);
    next_cycle();
    chk("rr0_gnt", a_gnt, 2'b01);
    chk("rr0_addr", a_mem_addr, 32'h40);
    chk("rr0_we", a_mem_we, 0);
    next_cycle();

    // Backpressure: two outstanding, pop in cycle N, next grant in N+1
    chk("bp_full_req", a_mem_req, 0);
    chk("bp_full_gnt", a_gnt, 0);
    chk("bp_full_busy", a_busy, 1);
    a_mem_rvalid = 1'b1; a_mem_rdata = 32'h11;
    #1;
    chk("bp_pop_rvalid", a_rvalid, 2'b10);
    chk("bp_pop_gnt", a_gnt, 0);
    chk("bp_pop_req", a_mem_req, 0);
    next_cycle();
    a_mem_rvalid = 1'b0;
    #1;
    chk("bp_next_gnt", a_gnt, 2'b10);
    chk("bp_next_req", a_mem_req, 1);
    next_cycle();
    a_req = 2'b00; a_mem_gnt = 1'b0;

    // Reset mid-flight with two routes outstanding
    a_req = 2'b01; a_mem_gnt = 1'b1;
    #1;
    chk("mid_busy_pre", a_busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_busy", a_busy, 0);
    chk("mid_mem_req", a_mem_req, 0);
    chk("mid_gnt", a_gnt, 0);
    chk("mid_mem_addr", a_mem_addr, 0);
    next_cycle();
    a_req = 2'b00; a_mem_gnt = 1'b0; rst_n = 1'b1;
    next_cycle();
    a_mem_rvalid = 1'b1; a_mem_rdata = 32'h55;
    #1;
    chk("mid_drop_rvalid", a_rvalid, 0);
    chk("mid_rdata_pass", a_rdata, 32'h55);
    next_cycle();
    a_mem_rvalid = 1'b0;
    #1;
    chk("mid_no_underflow", a_busy, 0);
`ifdef MEM_STREAM_RR_ARBITER_ERR_EN
    chk("mid_err", a_err, 1);
`endif

    // Fairness on b, responses one cycle after each grant
    for (int k = 0; k < 5; k++) begin
      b_req = (k < 4) ? 3'b111 : 3'b000;
      b_mem_gnt = (k < 4);
      b_mem_rvalid = (k > 0);
      b_mem_rdata = 32'h100 + k;
      #1;
      chk($sformatf("fair_gnt%0d", k), b_gnt, F_EG[k]);
      chk($sformatf("fair_rv%0d", k), b_rvalid, F_ER[k]);
      chk($sformatf("fair_rdata%0d", k), b_rdata, 32'h100 + k);
      next_cycle();
    end

    // Bring rr_q back to 0 via a grant to requester 2
    b_mem_rvalid = 1'b0; b_req = 3'b100; b_mem_gnt = 1'b1;
    #1;
    chk("rr2_gnt", b_gnt, 3'b100);
    next_cycle();
    b_req = 3'b000; b_mem_gnt = 1'b0; b_mem_rvalid = 1'b1;
    #1;
    chk("rr2_rv", b_rvalid, 3'b100);
    next_cycle();

    // Stall reselection
    b_mem_rvalid = 1'b0; b_req = 3'b010;
    #1;
    chk("stall1_addr", b_mem_addr, 32'h1010);
    chk("stall1_gnt", b_gnt, 0);
    next_cycle();
    b_req = 3'b011;
    #1;
    chk("stall2_addr", b_mem_addr, 32'h1000);
    chk("stall2_gnt", b_gnt, 0);
    next_cycle();
    b_mem_gnt = 1'b1;
    #1;
    chk("stall3_gnt", b_gnt, 3'b001);
    next_cycle();
    b_req = 3'b000; b_mem_gnt = 1'b0; b_mem_rvalid = 1'b1;
    #1;
    chk("stall_rv", b_rvalid, 3'b001);
    next_cycle();

    // Non-power-of-two pointer wrap
    for (int k = 0; k < 12; k++) begin
      b_req = W_REQ[k];
      b_mem_gnt = W_GNT[k];
      b_mem_rvalid = W_RV[k];
      b_mem_rdata = 32'h200 + k;
      #1;
      chk($sformatf("wrap_gnt%0d", k), b_gnt, W_EG[k]);
      chk($sformatf("wrap_rv%0d", k), b_rvalid, W_ER[k]);
      next_cycle();
    end
    b_mem_rvalid = 1'b0;
    #1;
    chk("wrap_idle_busy", b_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
